// File: rtl/mem_bank_sched_pkg.sv
// Shared encodings for the memory-bank playback scheduler: FSM states and
// the mem_bank mode constants.
package mem_bank_sched_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_RECORD    = 3'd0;
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd1;
    localparam logic [STATE_W-1:0] ST_PLAY_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] ST_PLAY      = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE      = 3'd4;

    localparam logic MODE_RECORD   = 1'b0;
    localparam logic MODE_PLAYBACK = 1'b1;

endpackage

// File: rtl/mem_bank_sched_rr_select.sv
// Combinational round-robin picker: the first requester strictly after the
// one-hot last_grant position wins, wrapping from NUM_CHAN-1 back to 0.
module rr_select #(
    parameter int NUM_CHAN = 4
) (
    input  logic [NUM_CHAN-1:0] req,
    input  logic [NUM_CHAN-1:0] last_grant,
    output logic [NUM_CHAN-1:0] winner
);

    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int s = 0; s < NUM_CHAN; s++) begin
            if (last_grant[s]) begin
                for (int k = 1; k <= NUM_CHAN; k++) begin
                    if (!found && req[(s + k) % NUM_CHAN]) begin
                        winner[(s + k) % NUM_CHAN] = 1'b1;
                        found                      = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_bank_sched.sv
// Arbitrates playback passes of a shared memory bank among NUM_CHAN
// requesters and interleaves record fills requested via refresh_req.
module mem_bank_sched
    import mem_bank_sched_pkg::*;
#(
    parameter int NUM_CHAN = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_CHAN-1:0] req,
    input  logic                refresh_req,
    input  logic                bank_ready,
    input  logic                bank_frame_start,
    input  logic                bank_frame_end,
    output logic                mem_mode,
    output logic [NUM_CHAN-1:0] grant,
    output logic [NUM_CHAN-1:0] pass_done,
    output logic                timeout_err,
    output logic                busy,
    output logic [STATE_W-1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
    // Pointing at the top channel makes the first search start at channel 0.
    localparam logic [NUM_CHAN-1:0] LAST_RST = {1'b1, {(NUM_CHAN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [NUM_CHAN-1:0] grant_q, grant_d;
    logic [NUM_CHAN-1:0] last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic                mem_mode_q, mem_mode_d;
    logic [NUM_CHAN-1:0] pass_done_q, pass_done_d;
    logic                timeout_err_q, timeout_err_d;
    logic                busy_q, busy_d;
    logic [NUM_CHAN-1:0] rr_win;
    logic                refresh_pend;

    rr_select #(
        .NUM_CHAN(NUM_CHAN)
    ) u_rr_select (
        .req        (req),
        .last_grant (last_q),
        .winner     (rr_win)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        pass_done_d   = '0;
        timeout_err_d = 1'b0;
        refresh_pend  = pend_q | refresh_req;

        case (state_q)
            ST_RECORD: begin
                if (bank_ready) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (refresh_pend || !bank_ready) begin
                    state_d = ST_RECORD;
                end else if (|req) begin
                    state_d = ST_PLAY_WAIT;
                    grant_d = rr_win;
                    last_d  = rr_win;
                    cnt_d   = '0;
                end
            end
            ST_PLAY_WAIT: begin
                // A frame that starts and ends in one cycle still counts as a full pass.
                if (bank_frame_start && bank_frame_end) begin
                    state_d     = ST_DONE;
                    pass_done_d = grant_q;
                    grant_d     = '0;
                end else if (bank_frame_start) begin
                    state_d = ST_PLAY;
                end else if (cnt_q == TMO) begin
                    state_d       = ST_DONE;
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (bank_frame_end) begin
                    state_d     = ST_DONE;
                    pass_done_d = grant_q;
                    grant_d     = '0;
                end
            end
            ST_DONE: begin
                state_d = refresh_pend ? ST_RECORD : ST_IDLE;
            end
            default: begin
                state_d = ST_RECORD;
                grant_d = '0;
            end
        endcase

        pend_d     = refresh_pend && !((state_d == ST_RECORD) && (state_q != ST_RECORD));
        mem_mode_d = (state_d == ST_RECORD) ? MODE_RECORD : MODE_PLAYBACK;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RECORD;
            grant_q       <= '0;
            last_q        <= LAST_RST;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            mem_mode_q    <= MODE_RECORD;
            pass_done_q   <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            mem_mode_q    <= mem_mode_d;
            pass_done_q   <= pass_done_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_mode    = mem_mode_q;
    assign grant       = grant_q;
    assign pass_done   = pass_done_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_bank_sched.sv
// Directed plus randomized bench for mem_bank_sched; grants are predicted by
// a round-robin reference model working on channel indices.
module tb_mem_bank_sched;
    import mem_bank_sched_pkg::*;

    localparam int NCH = 4;
    localparam int TO  = 15;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] req;
    logic           refresh_req;
    logic           bank_ready;
    logic           bank_frame_start;
    logic           bank_frame_end;
    logic           mem_mode;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] pass_done;
    logic           timeout_err;
    logic           busy;
    logic [STATE_W-1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int rr_last = NCH - 1;
    logic [NCH-1:0] exp_g;

    always #5 clk = ~clk;

    mem_bank_sched #(
        .NUM_CHAN (NCH),
        .TIMEOUT  (TO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .refresh_req      (refresh_req),
        .bank_ready       (bank_ready),
        .bank_frame_start (bank_frame_start),
        .bank_frame_end   (bank_frame_end),
        .mem_mode         (mem_mode),
        .grant            (grant),
        .pass_done        (pass_done),
        .timeout_err      (timeout_err),
        .busy             (busy),
        .dbg_state        (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: scan channel numbers after the last winner, modulo NCH.
    function automatic logic [NCH-1:0] model_pick(input logic [NCH-1:0] r);
        logic [NCH-1:0] w;
        int c;
        w = '0;
        for (int k = 1; k <= NCH; k++) begin
            c = (rr_last + k) % NCH;
            if (r[c]) begin
                w[c] = 1'b1;
                rr_last = c;
                return w;
            end
        end
        return w;
    endfunction

    // Starts at a falling edge with the DUT in IDLE; ends at a falling edge back in IDLE.
    task automatic run_pass(input logic [NCH-1:0] r, input int sdly, input int edly,
                            input bit same, input bit drop);
        logic [NCH-1:0] g;
        g = model_pick(r);
        req = r;
        @(negedge clk);
        chk("grant_load", grant, g);
        chk("busy_in_pass", busy, 1);
        if (drop) req = '0;
        for (int i = 0; i < sdly; i++) begin
            @(negedge clk);
            chk("grant_hold_wait", grant, g);
            chk("no_early_done", pass_done, 0);
        end
        bank_frame_start = 1'b1;
        bank_frame_end   = same;
        @(negedge clk);
        bank_frame_start = 1'b0;
        bank_frame_end   = 1'b0;
        if (!same) begin
            chk("grant_hold_play", grant, g);
            for (int i = 0; i < edly; i++) begin
                @(negedge clk);
                chk("grant_hold_play", grant, g);
            end
            bank_frame_end = 1'b1;
            @(negedge clk);
            bank_frame_end = 1'b0;
        end
        chk("pass_done", pass_done, g);
        chk("grant_clear_done", grant, 0);
        chk("no_timeout_err", timeout_err, 0);
        @(negedge clk);
        chk("pass_done_one_cycle", pass_done, 0);
        chk("idle_after_pass", busy, 0);
    endtask

    initial begin
        reset_n = 1'b0; req = '0; refresh_req = 1'b0; bank_ready = 1'b0;
        bank_frame_start = 1'b0; bank_frame_end = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_mode", mem_mode, 0);
        chk("rst_grant", grant, 0);
        chk("rst_pass_done", pass_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_busy", busy, 1);
        chk("rst_state", dbg_state, ST_RECORD);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("record_until_ready", mem_mode, 0);
        end
        bank_ready = 1'b1;
        @(negedge clk);
        chk("ready_mode_play", mem_mode, 1);
        chk("ready_state_idle", dbg_state, ST_IDLE);
        chk("ready_grant_zero", grant, 0);
        chk("ready_busy_low", busy, 0);

        // Frame pulses while idle must be ignored
        bank_frame_start = 1'b1; bank_frame_end = 1'b1;
        @(negedge clk);
        bank_frame_start = 1'b0; bank_frame_end = 1'b0;
        chk("ign_frame_busy", busy, 0);
        chk("ign_frame_done", pass_done, 0);
        @(negedge clk);
        chk("ign_frame_done2", pass_done, 0);

        // All channels requesting: grants rotate 0,1,2,3,0
        for (int i = 0; i < 5; i++) run_pass(4'b1111, 1, 1, 1'b0, 1'b0);

        // Start and end in the same PLAY_WAIT cycle
        run_pass(4'b1111, 0, 0, 1'b1, 1'b0);
        run_pass(4'b1111, 2, 0, 1'b1, 1'b0);

        // Randomized passes, including mid-pass req drop
        for (int i = 0; i < 12; i++) begin
            run_pass(4'($urandom_range(1, 15)), $urandom_range(0, 6), $urandom_range(0, 4),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        req = '0;
        @(negedge clk);
        chk("idle_no_req", busy, 0);

        // Timeout: no frame_start after grant
        req = 4'b0010;
        exp_g = model_pick(req);
        @(negedge clk);
        chk("to_grant", grant, exp_g);
        req = '0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            chk("to_wait_err", timeout_err, 0);
            chk("to_wait_grant", grant, exp_g);
        end
        @(negedge clk);
        chk("to_err_pulse", timeout_err, 1);
        chk("to_grant_clr", grant, 0);
        chk("to_no_pass_done", pass_done, 0);
        @(negedge clk);
        chk("to_err_one_cycle", timeout_err, 0);
        chk("to_back_idle", busy, 0);

        // Refresh arrives during channel 2's pass
        req = 4'b0101;
        exp_g = model_pick(req);
        @(negedge clk);
        chk("ref_grant_ch2", grant, 4'b0100);
        bank_frame_start = 1'b1;
        @(negedge clk);
        bank_frame_start = 1'b0;
        refresh_req = 1'b1;
        chk("ref_grant_hold", grant, exp_g);
        @(negedge clk);
        refresh_req = 1'b0;
        chk("ref_no_abort_grant", grant, exp_g);
        chk("ref_no_abort_mode", mem_mode, 1);
        bank_frame_end = 1'b1;
        @(negedge clk);
        bank_frame_end = 1'b0;
        chk("ref_pass_done", pass_done, 4'b0100);
        bank_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ref_record_mode", mem_mode, 0);
            chk("ref_record_grant", grant, 0);
            chk("ref_record_busy", busy, 1);
        end
        bank_ready = 1'b1;
        @(negedge clk);
        chk("ref_idle_mode", mem_mode, 1);
        chk("ref_idle_grant", grant, 0);
        run_pass(4'b0101, 1, 2, 1'b0, 1'b0);

        // Refresh pulse in IDLE beats pending requests
        req = 4'b1111;
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
        chk("refidle_mode", mem_mode, 0);
        chk("refidle_grant", grant, 0);
        @(negedge clk);
        chk("refidle_back_mode", mem_mode, 1);
        chk("refidle_back_grant", grant, 0);
        run_pass(4'b1111, 0, 1, 1'b0, 1'b0);

        // bank_ready falling in IDLE forces record
        req = '0;
        bank_ready = 1'b0;
        @(negedge clk);
        chk("notready_mode", mem_mode, 0);
        chk("notready_busy", busy, 1);
        bank_ready = 1'b1;
        @(negedge clk);
        chk("ready_again_mode", mem_mode, 1);
        chk("ready_again_busy", busy, 0);

        // Reset during PLAY aborts asynchronously with no pulses
        req = 4'b1111;
        exp_g = model_pick(req);
        @(negedge clk);
        chk("rstmid_grant", grant, exp_g);
        bank_frame_start = 1'b1;
        @(negedge clk);
        bank_frame_start = 1'b0;
        bank_frame_end = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_async_grant", grant, 0);
        chk("rstmid_async_mode", mem_mode, 0);
        chk("rstmid_async_busy", busy, 1);
        @(negedge clk);
        bank_frame_end = 1'b0;
        req = '0;
        chk("rstmid_no_done", pass_done, 0);
        chk("rstmid_no_to", timeout_err, 0);
        rr_last = NCH - 1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid_idle_mode", mem_mode, 1);
        run_pass(4'b1111, 1, 0, 1'b0, 1'b0);
        req = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
